// File: rtl/votacao_pkg.sv
// votacao_pkg: shared state encoding, default sizing and tally-width helper for the voting controller
package votacao_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, CLOSE, REPORT} state_t;
  localparam int N_VOTERS_DEF = 3;
  localparam int TIMEOUT_DEF = 16;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin one-hot grant over req, pointer moves past the winner on advance
module arbitro_rr #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, ptr_n, idx;
  // descending scan so the requester closest to the pointer is assigned last and wins
  always_comb begin
    grant = '0;
    ptr_n = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        ptr_n = PW'((int'(idx) + 1) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= ptr_n;
  end
endmodule

// File: rtl/controle_votacao.sv
// controle_votacao: sequences one voting round, arbitrates ballots one per voter and reports the tally
module controle_votacao
  import votacao_pkg::*;
#(
  parameter int N_VOTERS = N_VOTERS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int CNT_W = cnt_w(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_req,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic                busy,
  output logic                done,
  output logic [N_VOTERS-1:0] ballot,
  output logic [N_VOTERS-1:0] voted,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    abstain_count,
  output logic                majority
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [N_VOTERS-1:0] eligible, grant;
  logic in_collect;
  assign in_collect = state == COLLECT;
  assign eligible = in_collect ? vote_req & ~voted : '0;
  assign busy = state != IDLE;
  assign done = state == REPORT;
  arbitro_rr #(.N(N_VOTERS)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(eligible),
    .advance(|grant),
    .grant(grant)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // exit tests the registered mask so done lands two cycles after the final ack
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? COLLECT : IDLE;
      COLLECT: state_n = (&voted || timer == TW'(TIMEOUT - 1)) ? CLOSE : COLLECT;
      CLOSE:   state_n = REPORT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vote_ack <= '0;
      voted <= '0;
      ballot <= '0;
      timer <= '0;
      yes_count <= '0;
      abstain_count <= '0;
      majority <= 1'b0;
    end else begin
      vote_ack <= grant;
      if (state == IDLE && start) begin
        voted <= '0;
        ballot <= '0;
        timer <= '0;
        yes_count <= '0;
        abstain_count <= '0;
        majority <= 1'b0;
      end
      if (in_collect) begin
        timer <= timer + 1'b1;
        voted <= voted | grant;
        ballot <= ballot | (grant & vote_val);
      end
      if (state == CLOSE) begin
        yes_count <= CNT_W'($countones(ballot));
        abstain_count <= CNT_W'(N_VOTERS - $countones(voted));
        majority <= 2 * $countones(ballot) > N_VOTERS;
      end
    end
  end
endmodule

// File: tb/tb_controle_votacao.sv
// tb_controle_votacao: directed and randomized voting rounds checked against a voter-level reference model
module tb_controle_votacao;
  import votacao_pkg::*;
  localparam int N = 3;
  localparam int TO = 16;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [N-1:0] vote_req = '0;
  logic [N-1:0] vote_val = '0;
  logic [N-1:0] vote_ack, ballot, voted;
  logic busy, done, majority;
  logic [CW-1:0] yes_count, abstain_count;
  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  logic [N-1:0] voted_m, ballot_m;
  int rf[N];
  logic [N-1:0] vv, stk;

  always #5 clk = ~clk;

  controle_votacao #(.N_VOTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .vote_req(vote_req), .vote_val(vote_val),
    .vote_ack(vote_ack), .busy(busy), .done(done), .ballot(ballot), .voted(voted),
    .yes_count(yes_count), .abstain_count(abstain_count), .majority(majority)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(vote_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ballot"}, 32'(ballot), 0);
    chk({tag, "_voted"}, 32'(voted), 0);
    chk({tag, "_yes"}, 32'(yes_count), 0);
    chk({tag, "_abs"}, 32'(abstain_count), 0);
    chk({tag, "_maj"}, 32'(majority), 0);
  endtask

  // voter i raises req from COLLECT cycle rf[i], drops it on ack unless sticky, may flip val once acked
  task automatic run_round(input logic [N-1:0] flip, input int mid_start, input bit start_in_report);
    logic [N-1:0] acked, req, elig, exp_ack;
    int yes, nv, w, j;
    bit open;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    start = 1'b1;
    vote_req = 3'($urandom);
    vote_val = 3'($urandom);
    @(negedge clk);
    start = 1'b0;
    voted_m = '0;
    ballot_m = '0;
    acked = '0;
    exp_ack = '0;
    open = 1'b1;
    j = 0;
    chk("clr_yes", 32'(yes_count), 0);
    chk("clr_abs", 32'(abstain_count), 0);
    while (open) begin
      chk("col_busy", 32'(busy), 1);
      chk("col_done", 32'(done), 0);
      chk("col_ack", 32'(vote_ack), 32'(exp_ack));
      chk("col_voted", 32'(voted), 32'(voted_m));
      chk("col_ballot", 32'(ballot), 32'(ballot_m));
      for (int i = 0; i < N; i++) begin
        req[i] = (j >= rf[i]) && (!acked[i] || stk[i]);
        vote_val[i] = req[i] ? (acked[i] && flip[i] ? ~vv[i] : vv[i]) : 1'($urandom);
      end
      vote_req = req;
      start = j == mid_start;
      elig = req & ~voted_m;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && elig[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      if (voted_m == '1 || j == TO - 1) open = 1'b0;
      exp_ack = '0;
      if (w >= 0) begin
        voted_m[w] = 1'b1;
        ballot_m[w] = vote_val[w];
        acked[w] = 1'b1;
        exp_ack[w] = 1'b1;
        ptr_m = (w + 1) % N;
      end
      j++;
      @(negedge clk);
    end
    start = 1'b0;
    vote_req = 3'($urandom);
    vote_val = 3'($urandom);
    chk("cls_busy", 32'(busy), 1);
    chk("cls_done", 32'(done), 0);
    chk("cls_ack", 32'(vote_ack), 32'(exp_ack));
    yes = 0;
    nv = 0;
    for (int i = 0; i < N; i++) begin
      yes += int'(ballot_m[i]);
      nv += int'(voted_m[i]);
    end
    @(negedge clk);
    start = start_in_report;
    vote_req = 3'($urandom);
    chk("rep_busy", 32'(busy), 1);
    chk("rep_done", 32'(done), 1);
    chk("rep_ack", 32'(vote_ack), 0);
    chk("rep_voted", 32'(voted), 32'(voted_m));
    chk("rep_ballot", 32'(ballot), 32'(ballot_m));
    chk("rep_yes", 32'(yes_count), yes);
    chk("rep_abs", 32'(abstain_count), N - nv);
    chk("rep_maj", 32'(majority), (2 * yes > N) ? 1 : 0);
    @(negedge clk);
    start = 1'b0;
    vote_req = '0;
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 0);
    chk("end_yes", 32'(yes_count), yes);
    chk("end_maj", 32'(majority), (2 * yes > N) ? 1 : 0);
  endtask

  initial begin
    // reset with noisy inputs
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom);
      vote_req = 3'($urandom);
      vote_val = 3'($urandom);
      @(negedge clk);
      chk_zero("rst");
    end
    rst = 1'b0;
    start = 1'b0;
    vote_req = '0;
    ptr_m = 0;
    // nobody votes: full timeout
    rf = '{99, 99, 99}; vv = 3'b000; stk = 3'b000;
    run_round(3'b000, -1, 1'b0);
    // simultaneous requests
    rf = '{0, 0, 0}; vv = 3'b101; stk = 3'b000;
    run_round(3'b000, -1, 1'b0);
    // lone voter then timeout
    rf = '{99, 0, 99}; vv = 3'b010; stk = 3'b000;
    run_round(3'b000, -1, 1'b0);
    // voter 0 holds req and flips its value after ack
    rf = '{0, 0, 0}; vv = 3'b001; stk = 3'b001;
    run_round(3'b001, -1, 1'b0);
    // staggered round ending on voter 2, then all request with stray starts
    rf = '{0, 1, 2}; vv = 3'b110; stk = 3'b000;
    run_round(3'b000, -1, 1'b0);
    rf = '{0, 0, 0}; vv = 3'b011; stk = 3'b000;
    run_round(3'b000, 1, 1'b1);
    // reset in the middle of a round
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote_req = 3'b001;
    vote_val = 3'b001;
    @(negedge clk);
    chk("mid_ack", 32'(vote_ack), 1);
    vote_req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    chk_zero("mid_rst");
    rf = '{1, 0, 2}; vv = 3'b111; stk = 3'b000;
    run_round(3'b000, -1, 1'b0);
    // randomized rounds
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) rf[i] = int'($urandom_range(0, 20));
      vv = 3'($urandom);
      stk = 3'($urandom);
      run_round(3'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
